// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud generator: default widths,
// reset-divisor helper and the generator FSM state type.
package uart_pkg;

  localparam int unsigned DIV_W_DEF  = 16;
  localparam int unsigned FRAC_W_DEF = 4;

  typedef enum logic {
    IDLE,
    RUN
  } baud_state_e;

  // Integer clock cycles per oversample tick at the out-of-reset baud rate.
  function automatic int unsigned default_div(input int unsigned fclk,
                                              input int unsigned baud,
                                              input int unsigned os);
    int unsigned den;
    den = baud * os;
    if (den == 0) return 1;
    return fclk / den;
  endfunction

endpackage

// File: rtl/uart_baud_prescaler.sv
// Down-counting prescaler for the baud generator. Reloads to div-1 (or div
// when the fractional accumulator carries) and emits a registered raw tick.
// Fractional stretching is built only when UART_BAUD_FRAC_EN is defined.
module uart_baud_prescaler #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [DIV_W-1:0]  div,
  input  logic [FRAC_W-1:0] frac,
  output logic              fire,
  output logic              tick
);

  logic [DIV_W-1:0] cnt_q;
  logic             carry;

  assign fire = run && (cnt_q == '0);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, frac};
  assign carry   = acc_sum[FRAC_W];

  // Fractional phase accumulator, advanced once per emitted tick.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      acc_q <= '0;
    end else if (fire) begin
      acc_q <= acc_sum[FRAC_W-1:0];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^frac;
  assign carry       = 1'b0;
`endif

  // Count down while running; reload on zero, on explicit load or in idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= fire;
      if (load) begin
        cnt_q <= div - DIV_W'(1);
      end else if (run) begin
        if (fire) begin
          cnt_q <= carry ? div : div - DIV_W'(1);
        end else begin
          cnt_q <= cnt_q - DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: programmable oversample tick (os_tick) and bit tick
// (tx_tick) with shadowed divisor updates and RX phase restart.
// Optional fractional divisor enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned FCLK         = 50_000_000,
  parameter int unsigned BAUD_DEFAULT = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_W        = DIV_W_DEF,
  parameter int unsigned FRAC_W       = FRAC_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  input  logic                          phase_restart,
  output logic                          os_tick,
  output logic                          tx_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int unsigned      PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(default_div(FCLK, BAUD_DEFAULT, OVERSAMPLE));

  baud_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_nxt, div_eff;
  logic [FRAC_W-1:0] frac_eff;
  logic              ps_load, ps_run, fire;

  // The shadow is the only divisor store: the counter reads it solely at
  // reload, so a mid-count update naturally waits for the next period.
  // Bypassing the strobe lets an update coincident with a reload take effect.
  assign div_nxt = div_load ? div_int : div_q;
  assign div_eff = (div_nxt == '0) ? DIV_W'(1) : div_nxt;

  // Shadow integer divisor; reset restores the default rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DEF_DIV;
    end else if (div_load) begin
      div_q <= div_int;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q;

  assign frac_eff = div_load ? div_frac : frac_q;

  // Shadow fractional divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q <= '0;
    end else if (div_load) begin
      frac_q <= div_frac;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign frac_eff    = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and prescaler control; en=0 outranks phase_restart.
  always_comb begin
    state_d = state_q;
    ps_load = 1'b0;
    ps_run  = 1'b0;
    case (state_q)
      IDLE: begin
        ps_load = 1'b1;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (phase_restart) begin
          ps_load = 1'b1;
        end else begin
          ps_run = 1'b1;
        end
      end
    endcase
  end

  uart_baud_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .load (ps_load),
    .run  (ps_run),
    .div  (div_eff),
    .frac (frac_eff),
    .fire (fire),
    .tick (os_tick)
  );

  // Oversample index and bit tick, updated on the same edge as os_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_phase <= '0;
      tx_tick  <= 1'b0;
    end else begin
      tx_tick <= 1'b0;
      if (!ps_run) begin
        os_phase <= '0;
      end else if (fire) begin
        os_phase <= os_phase + PH_W'(1);
        tx_tick  <= (os_phase == PH_MAX);
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed self-checking bench for uart_baud_gen (default parameters,
// D=325 out of reset). Fractional expectations follow UART_BAUD_FRAC_EN.
module tb_uart_baud_gen;

`ifdef UART_BAUD_FRAC_EN
  localparam int EXP_P2  = 5;
  localparam int EXP_SUM = 144;
`else
  localparam int EXP_P2  = 4;
  localparam int EXP_SUM = 128;
`endif

  logic        clk = 1'b0;
  logic        rst, en, div_load, phase_restart;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, tx_tick;
  logic [3:0]  os_phase;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int n;
  int sum;

  always #5 clk = ~clk;

  uart_baud_gen #(
    .FCLK         (50_000_000),
    .BAUD_DEFAULT (9600),
    .OVERSAMPLE   (16),
    .DIV_W        (16),
    .FRAC_W       (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .div_int       (div_int),
    .div_frac      (div_frac),
    .div_load      (div_load),
    .phase_restart (phase_restart),
    .os_tick       (os_tick),
    .tx_tick       (tx_tick),
    .os_phase      (os_phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Negedges until os_tick is seen (bounded by limit).
  task automatic next_tick(input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!os_tick && cnt < limit);
  endtask

  task automatic next_tx(input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tx_tick && cnt < limit);
  endtask

  // Drop en, load a divisor in IDLE, then raise en before the next edge.
  task automatic restart_with(input logic [15:0] d, input logic [3:0] f);
    en = 1'b0;
    step(1);
    div_int  = d;
    div_frac = f;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    en       = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; phase_restart = 1'b0;
    div_int = '0; div_frac = '0;
    step(3);
    rst = 1'b0;
    step(1);
    check("reset_os_tick", os_tick, 0);
    check("reset_tx_tick", tx_tick, 0);
    check("reset_os_phase", os_phase, 0);

    // Default divisor 325
    en = 1'b1;
    next_tick(400, n);  check("def_first", n, 326);
    next_tick(400, n);  check("def_period", n, 325);
    check("def_phase2", os_phase, 2);
    next_tx(6000, n);   check("def_tx_first", n, 4550);
    check("def_tx_phase", os_phase, 0);
    check("def_tx_os", os_tick, 1);
    next_tx(6000, n);   check("def_tx_period", n, 5200);

    // D=4 loaded in IDLE
    en = 1'b0;
    step(2);
    check("drop_os_tick", os_tick, 0);
    check("drop_phase", os_phase, 0);
    restart_with(16'd4, 4'd0);
    next_tick(50, n);   check("d4_first", n, 5);
    check("d4_phase1", os_phase, 1);
    for (int k = 2; k <= 16; k++) begin
      next_tick(50, n);
      check("d4_period", n, 4);
      if (k == 15) check("d4_no_tx", tx_tick, 0);
    end
    check("d4_tx", tx_tick, 1);
    check("d4_tx_phase", os_phase, 0);

    // Fractional D=4, F=8
    restart_with(16'd4, 4'd8);
    next_tick(50, n);   check("frac_first", n, 5);
    sum = 0;
    for (int k = 1; k <= 32; k++) begin
      next_tick(50, n);
      sum += n;
      if (k == 1) check("frac_p1", n, 4);
      if (k == 2) check("frac_p2", n, EXP_P2);
    end
    check("frac_sum32", sum, EXP_SUM);

    // Mid-run div_load at count 5, D=10 -> 3
    restart_with(16'd10, 4'd0);
    next_tick(50, n);   check("d10_first", n, 11);
    step(4);
    div_int = 16'd3; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    next_tick(50, n);   check("d10_completes", n, 5);
    next_tick(50, n);   check("d3_period_a", n, 3);
    next_tick(50, n);   check("d3_period_b", n, 3);

    // Back-to-back loads: 6 then 2, only 2 applies
    div_int = 16'd6; div_load = 1'b1;
    step(1);
    div_int = 16'd2;
    step(1);
    div_load = 1'b0;
    next_tick(50, n);   check("b2b_finish", n, 1);
    next_tick(50, n);   check("b2b_period_a", n, 2);
    next_tick(50, n);   check("b2b_period_b", n, 2);

    // phase_restart at os_phase=7, D=8
    restart_with(16'd8, 4'd0);
    for (int k = 0; k < 7; k++) next_tick(50, n);
    check("pr_phase7", os_phase, 7);
    step(3);
    phase_restart = 1'b1;
    step(1);
    phase_restart = 1'b0;
    check("pr_no_tick", os_tick, 0);
    check("pr_phase0", os_phase, 0);
    next_tick(50, n);   check("pr_next", n, 8);
    check("pr_phase1", os_phase, 1);
    next_tx(500, n);    check("pr_tx", n, 120);
    check("pr_tx_phase", os_phase, 0);

    // div_int=0 clamps to 1
    restart_with(16'd0, 4'd0);
    next_tick(50, n);   check("d0_first", n, 2);
    next_tick(50, n);   check("d0_period_a", n, 1);
    next_tick(50, n);   check("d0_period_b", n, 1);

    // en dropped on the count-0 cycle
    restart_with(16'd4, 4'd0);
    next_tick(50, n);   check("endrop_first", n, 5);
    step(3);
    check("endrop_pre", os_tick, 0);
    en = 1'b0;
    step(1);
    check("endrop_os", os_tick, 0);
    check("endrop_tx", tx_tick, 0);
    check("endrop_phase", os_phase, 0);
    step(4);
    check("endrop_idle", os_tick, 0);
    en = 1'b1;
    next_tick(50, n);   check("endrop_rerun", n, 5);

    // rst during RUN restores default divisor
    step(1);
    rst = 1'b1;
    step(1);
    check("rst_os", os_tick, 0);
    check("rst_tx", tx_tick, 0);
    check("rst_phase", os_phase, 0);
    rst = 1'b0;
    next_tick(400, n);  check("rst_default_d", n, 326);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Parametrised successor to the fixed-rate baud tick counter.
- Generates a 1-cycle oversample tick (os_tick) and a 1-cycle bit tick (tx_tick) from a runtime-programmable integer+fractional divisor.
- Sits between the APB register block (divisor/enable source) and the UART TX/RX engines.
- RX can restart the phase on start-bit detection.

Parameters:
- FCLK, 50_000_000, system clock in Hz; used only to compute the reset divisor.
- BAUD_DEFAULT, 9600, baud rate in effect out of reset.
- OVERSAMPLE, 16, os_ticks per bit; power of two, 4..32.
- DIV_W, 16, integer divisor width.
- FRAC_W, 4, fractional divisor width (units of 1/2^FRAC_W cycle).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  generator enable (level)
- div_int  in  DIV_W  integer divisor D = clk cycles per os_tick
- div_frac  in  FRAC_W  fractional divisor F
- div_load  in  1  1-cycle strobe; capture div_int/div_frac into shadow
- phase_restart  in  1  1-cycle strobe; realign prescaler and oversample counter
- os_tick  out  1  registered 1-cycle pulse every D(+1) cycles
- tx_tick  out  1  registered 1-cycle pulse coincident with every OVERSAMPLE-th os_tick
- os_phase  out  $clog2(OVERSAMPLE)  current oversample index (0 at tx_tick)

Behaviour:
- Reset values:
  - os_tick=0, tx_tick=0, os_phase=0, accumulator=0, FSM=IDLE.
  - Active divisor = FCLK/(BAUD_DEFAULT*OVERSAMPLE) integer part; F=0.
- Divisor clamp: effective D = max(active D, 1). D=1 gives os_tick every cycle.
- FSM states:
  - IDLE: en=0. Prescaler held at D-1, os_phase=0, accumulator=0, ticks 0.
    - div_load applies immediately.
    - en=1 sampled → RUN.
  - RUN: prescaler decrements each cycle.
    - At count 0: os_tick=1 next cycle; reload D-1, or D when fractional carry.
    - en=0 sampled → IDLE next cycle. No tick in that cycle, even if the count hit 0.
- Timing: first os_tick is asserted D cycles after the edge that first samples en=1. Thereafter os_tick repeats every D cycles.
- Oversample counter:
  - os_phase increments on each os_tick and wraps OVERSAMPLE-1 → 0.
  - tx_tick=1 in the same cycle as the os_tick that wraps os_phase to 0.
  - First tx_tick therefore follows the OVERSAMPLE-th os_tick.
- Divisor update while in RUN:
  - div_load captures the value into a shadow register.
  - The shadow is applied at the next reload, so there are no runt or stretched periods mid-count.
  - A second div_load before that reload overwrites the shadow; the last value wins.
- phase_restart (RUN only; ignored in IDLE):
  - Prescaler reloads to D-1, os_phase=0, accumulator=0.
  - Next os_tick comes D cycles later.
  - No tick is emitted in the restart cycle, even if the count hit 0.
- Simultaneous events, priority: rst > en=0 > phase_restart > div_load. div_load alongside phase_restart: the new divisor is used for the restarted period.
- rst mid-operation: all state returns to reset values the next cycle, and the default divisor is restored.
- Arithmetic: prescaler width DIV_W. The accumulator is FRAC_W bits; carry = bit FRAC_W of (acc + F).

Optional Feature:
- Macro: UART_BAUD_FRAC_EN.
- Defined:
  - At each os_tick, acc ← (acc+F) mod 2^FRAC_W.
  - On carry, the period starting at that tick is D+1 cycles.
  - Mean period = D + F/2^FRAC_W.
- Undefined:
  - div_frac is ignored and the accumulator is not built.
  - Every period is exactly D; port list unchanged.

Decomposition:
- Package uart_pkg:
  - DIV_W/FRAC_W defaults.
  - Function computing the default divisor from FCLK, BAUD_DEFAULT, OVERSAMPLE.
  - FSM state enum (IDLE, RUN).
- One sub-module, uart_baud_prescaler:
  - Down-counter with reload, clamp and fractional stretch; emits a raw tick.
  - Top level owns the FSM, shadow register, os_phase and tx_tick.

Test Plan:
- Reset release, en=1, no div_load, FCLK=50M, BAUD=9600, OVERSAMPLE=16 → D=325; os_tick every 325 cycles; tx_tick every 5200 cycles.
- div_int=4 loaded in IDLE, en raised at edge 0 → os_tick at edges 4, 8, 12…; tx_tick at edge 64; os_phase=0 at that tick.
- UART_BAUD_FRAC_EN, D=4, F=8, FRAC_W=4 → period sequence 4, 4, 5, 4, 5, 4, 5…; average 4.5 over 32 ticks.
- In RUN with D=10, div_load D=3 at count 5 → current period completes at 10; following periods are 3. Two back-to-back div_loads → only the second takes effect.
- phase_restart at os_phase=7 mid-count, D=8 → no tick that cycle; os_tick 8 cycles later with os_phase=1; tx_tick after 16 os_ticks from restart.
- Edge cases:
  - div_int=0 → os_tick every cycle.
  - en dropped on the count-0 cycle → no tick; outputs 0; IDLE.
  - rst during RUN → all outputs 0 next cycle; default D restored.
